codificador_teclas: RTL and testbench

CODIFICADOR_TECLAS -- requirements
Module: codificador_teclas

---
 rtl/codificador_teclas.sv | 161 ++++++++++++++++
 tb/tb_codificador_teclas.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/codificador_teclas.sv
`default_nettype none
// ============================================================================
//  Module      : codificador_teclas
//  Description : Debounced priority encoder for a 12-key piano keyboard.
//                Synchronises the raw keys, picks the lowest pressed key,
//                waits for DEBOUNCE_CYCLES stable clocks, and then publishes
//                the note code (key index + 1, 0 = none) with a one-clock
//                nota_valida pulse. Release is debounced the same way.
//  Build macro : CODIFICADOR_TECLAS_SINCRONIZADOR_EN - when defined, a 2-flop
//                synchronizer sits in front of the encoder (latency N+3);
//                when undefined, keys feed the encoder directly (latency N+1).
//  Revision    : 1.0 - initial release
// ============================================================================
module codificador_teclas #(
    parameter int CLOCK_FREQ      = 50000000,
    parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] teclas,
    output logic [3:0]  botoes_encoded,
    output logic        nota_valida,
    output logic [1:0]  db_estado
);

    // Counter only ever needs to reach N-1; keep at least one bit for N=1.
    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        ESTABILIZA  = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTA       = 2'd3
    } estado_t;

    estado_t              r_state, w_state_next;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
    logic [3:0]           r_cand, w_cand_next;
    logic [3:0]           r_code, w_code_next;
    logic                 r_pulse, w_pulse_next;

    logic [11:0]          w_sync;
    logic [3:0]           w_prio;
    logic                 w_held;

`ifdef CODIFICADOR_TECLAS_SINCRONIZADOR_EN
    logic [11:0] r_meta;
    logic [11:0] r_sync;

    // Two-flop synchronizer for the asynchronous key lines.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 12'd0;
            r_sync <= 12'd0;
        end else begin
            r_meta <= teclas;
            r_sync <= r_meta;
        end
    end

    assign w_sync = r_sync;
`else
    assign w_sync = teclas;
`endif

    // Lowest pressed key wins; scanning downwards lets the lowest index overwrite.
    always_comb begin
        w_prio = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (w_sync[i]) begin
                w_prio = 4'(i + 1);
            end
        end
    end

    // Current level of the key that was accepted as the candidate.
    always_comb begin
        w_held = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (r_cand == 4'(i + 1)) begin
                w_held = w_sync[i];
            end
        end
    end

    // Next-state and next-output logic of the debounce FSM.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_code_next  = r_code;
        w_pulse_next = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (w_prio != 4'd0) begin
                    w_cand_next  = w_prio;
                    w_cnt_next   = '0;
                    w_state_next = ESTABILIZA;
                end
            end
            ESTABILIZA: begin
                if (w_prio != r_cand) begin
                    w_state_next = OCIOSO;
                end else if (r_cnt == c_last) begin
                    w_state_next = PRESSIONADO;
                    w_code_next  = r_cand;
                    w_pulse_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_one;
                end
            end
            PRESSIONADO: begin
                // Other keys are deliberately ignored while the candidate is held.
                if (!w_held) begin
                    w_state_next = SOLTA;
                    w_cnt_next   = '0;
                end
            end
            SOLTA: begin
                // A bounce back to pressed re-arms the hold without a new pulse.
                if (w_held) begin
                    w_state_next = PRESSIONADO;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_last) begin
                    w_state_next = OCIOSO;
                    w_code_next  = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + c_one;
                end
            end
            default: begin
                w_state_next = OCIOSO;
            end
        endcase
    end

    // State, counter, candidate and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= OCIOSO;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
            r_code  <= 4'd0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
            r_code  <= w_code_next;
            r_pulse <= w_pulse_next;
        end
    end

    assign botoes_encoded = r_code;
    assign nota_valida    = r_pulse;
    assign db_estado      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_codificador_teclas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_codificador_teclas
//  Description : Directed self-checking bench for codificador_teclas with a
//                4-clock debounce window. Latencies follow the
//                CODIFICADOR_TECLAS_SINCRONIZADOR_EN build selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_codificador_teclas;

    localparam int c_n = 4;
`ifdef CODIFICADOR_TECLAS_SINCRONIZADOR_EN
    localparam int c_d = 2;
`else
    localparam int c_d = 0;
`endif
    // Edges from a raw change to the visible code.
    localparam int c_lat = c_n + 1 + c_d;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] teclas = 12'd0;
    logic [3:0]  botoes_encoded;
    logic        nota_valida;
    logic [1:0]  db_estado;

    int tests = 0;
    int fails = 0;

    codificador_teclas #(
        .CLOCK_FREQ      (1000),
        .DEBOUNCE_CYCLES (c_n)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .teclas         (teclas),
        .botoes_encoded (botoes_encoded),
        .nota_valida    (nota_valida),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] code,
                           input logic pulse, input logic [1:0] st);
        chk({tag, ".code"},  botoes_encoded, code);
        chk({tag, ".pulse"}, {3'd0, nota_valida}, {3'd0, pulse});
        chk({tag, ".state"}, {2'd0, db_estado}, {2'd0, st});
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        ticks(2);
        chk_all("reset", 4'd0, 1'b0, 2'd0);
        reset = 1'b0;
        tick();
        chk_all("idle", 4'd0, 1'b0, 2'd0);

        // Key 4 pressed: code 5 appears exactly at the latency edge
        teclas = 12'h010;
        for (int k = 1; k < c_lat; k++) begin
            tick();
            chk("k4_wait.code", botoes_encoded, 4'd0);
            chk("k4_wait.pulse", {3'd0, nota_valida}, 4'd0);
        end
        tick();
        chk_all("k4_accept", 4'd5, 1'b1, 2'd2);
        tick();
        chk_all("k4_after", 4'd5, 1'b0, 2'd2);

        // Adding lower key 0 is ignored while key 4 is held
        teclas = 12'h011;
        ticks(10);
        chk_all("k4_plus_k0", 4'd5, 1'b0, 2'd2);

        // Release key 4 with key 0 still held
        teclas = 12'h001;
        ticks(c_lat - 1);
        chk_all("k4_release_wait", 4'd5, 1'b0, 2'd3);
        tick();
        chk_all("k4_released", 4'd0, 1'b0, 2'd0);
        ticks(c_n);
        chk_all("k0_wait", 4'd0, 1'b0, 2'd1);
        tick();
        chk_all("k0_accept", 4'd1, 1'b1, 2'd2);
        tick();
        chk("k0_after.pulse", {3'd0, nota_valida}, 4'd0);

        teclas = 12'h000;
        ticks(c_lat);
        chk_all("k0_released", 4'd0, 1'b0, 2'd0);
        ticks(3);

        // Short glitch on key 0 (3 cycles) must be rejected
        teclas = 12'h001;
        ticks(3);
        teclas = 12'h000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch.code", botoes_encoded, 4'd0);
            chk("glitch.pulse", {3'd0, nota_valida}, 4'd0);
        end
        chk("glitch.state", {2'd0, db_estado}, 4'd0);

        // Key 2 held, dropped 2 cycles inside SOLTA, reasserted
        teclas = 12'h004;
        ticks(c_lat);
        chk_all("k2_accept", 4'd3, 1'b1, 2'd2);
        tick();
        teclas = 12'h000;
        ticks(2);
        teclas = 12'h004;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("k2_bounce.code", botoes_encoded, 4'd3);
            chk("k2_bounce.pulse", {3'd0, nota_valida}, 4'd0);
        end
        chk("k2_bounce.state", {2'd0, db_estado}, 4'd2);
        teclas = 12'h000;
        ticks(c_lat);
        chk_all("k2_released", 4'd0, 1'b0, 2'd0);
        ticks(3);

        // Highest key and multi-key priority
        teclas = 12'h800;
        ticks(c_lat);
        chk_all("k11_accept", 4'd12, 1'b1, 2'd2);
        teclas = 12'h000;
        ticks(c_lat);
        chk("k11_released.code", botoes_encoded, 4'd0);
        ticks(3);
        teclas = 12'hA40;
        ticks(c_lat);
        chk_all("multi_accept", 4'd7, 1'b1, 2'd2);
        teclas = 12'h000;
        ticks(c_lat + 3);
        chk("multi_released.code", botoes_encoded, 4'd0);

        // Reset during ESTABILIZA
        teclas = 12'h010;
        ticks(c_d + 2);
        chk("pre_rst_est.state", {2'd0, db_estado}, 4'd1);
        reset = 1'b1;
        tick();
        chk_all("rst_est", 4'd0, 1'b0, 2'd0);
        teclas = 12'h000;
        tick();
        reset = 1'b0;
        ticks(3);

        // Reset during SOLTA
        teclas = 12'h010;
        ticks(c_lat);
        chk("pre_rst_solta.code", botoes_encoded, 4'd5);
        teclas = 12'h000;
        ticks(c_d + 2);
        chk_all("pre_rst_solta", 4'd5, 1'b0, 2'd3);
        reset = 1'b1;
        tick();
        chk_all("rst_solta", 4'd0, 1'b0, 2'd0);
        reset = 1'b0;
        ticks(3);

        // Reset coinciding with the acceptance edge
        teclas = 12'h020;
        ticks(c_lat - 1);
        reset = 1'b1;
        tick();
        chk_all("rst_accept", 4'd0, 1'b0, 2'd0);
        teclas = 12'h000;
        reset = 1'b0;
        ticks(3);
        chk_all("final_idle", 4'd0, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
